segrw_initiator: RTL and testbench
==================================

Name: segrw_initiator

Overview:
- Initiator side of the segment read/write stream interface. Drives addr/dataW/write tokens into a segrw-style segment data path and collects the returned read-data tokens.
- Accepts burst commands (base address, length, read or fill-write) from an upstream operator. Expands each command into per-address segment tokens, with address wrap-around.
- Limits in-flight reads with a credit counter and returns read data in order through a 1-entry registered output buffer.

Parameters:
- ADDR_W, 4, segment address width (segment depth 2^ADDR_W words)
- DATA_W, 8, data word width
- LEN_W, 4, burst length field width (burst = cmd_len+1 words)
- MAX_OUT, 4, maximum outstanding reads (1..7; counter is 3 bits)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_addr  in  ADDR_W  burst base address
- cmd_data  in  DATA_W  fill value for write bursts
- cmd_write  in  1  1=fill-write burst, 0=read burst
- cmd_len  in  LEN_W  burst length minus one
- cmd_valid  in  1  command token present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- addr_d  out  ADDR_W  segment address token
- dataW_d  out  DATA_W  segment write-data token
- write_d  out  1  segment write-enable token
- seg_valid  out  1  segment token triple valid
- seg_ready  in  1  segment consumes token on seg_valid&seg_ready
- dataR_d  in  DATA_W  read data returned by segment
- dataR_valid  in  1  read data present
- dataR_ready  out  1  initiator accepts read data
- rd_data  out  DATA_W  read result to downstream
- rd_valid  out  1  read result valid
- rd_ready  in  1  downstream accepts result
- burst_done  out  1  one-cycle pulse when last token of a burst is issued
- err_unexp  out  1  sticky: read data arrived with zero outstanding

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters 0. Outputs: cmd_ready=0, seg_valid=0, rd_valid=0, burst_done=0, err_unexp=0. addr_d/dataW_d/write_d=0. dataR_ready=1 (rd buffer empty).
- Reset mid-burst abandons the burst. Tokens not yet consumed are dropped; read data in flight is lost.
- FSM states: IDLE, ISSUE.
- IDLE: cmd_ready=1, seg_valid=0.
  - On cmd_valid, latch cur_addr=cmd_addr, data, write, remaining=cmd_len, then go to ISSUE.
  - Latency: first seg_valid asserts the cycle after acceptance.
- ISSUE: cmd_ready=0. seg_valid=1 unless (write_d=0 and outstanding==MAX_OUT); in that case seg_valid=0 (read stall).
  - Token fields are registered (addr_d=cur_addr, dataW_d=latched data, write_d=latched write). They are stable while seg_valid=1 and seg_ready=0.
  - Token transfer: cur_addr<=cur_addr+1 mod 2^ADDR_W (wraps 15->0) and remaining<=remaining-1.
  - If remaining==0 at transfer: pulse burst_done next cycle and return to IDLE. A new command is accepted no earlier than the cycle after the return.
  - dataW_d during reads is don't-care; drive the latched data.
- Outstanding counter:
  - +1 on read-token transfer; -1 on read-data acceptance (dataR_valid&dataR_ready).
  - Both in the same cycle: unchanged. Never exceeds MAX_OUT.
  - Write tokens do not touch the counter.
- Read return path:
  - dataR_ready = !rd_valid | rd_ready.
  - On acceptance, rd_data<=dataR_d and rd_valid<=1, one cycle of latency.
  - rd_valid clears on rd_ready with no new acceptance.
  - Back-to-back throughput is one word/cycle when rd_ready=1.
- Acceptance with outstanding==0: the data is still forwarded, err_unexp<=1 (sticky until reset), and the counter stays 0 (no underflow).
- The segment returns reads in order; the initiator does no tagging.
- Commands with cmd_len=0 issue exactly one token.
- Bursts longer than 2^ADDR_W are impossible when LEN_W==ADDR_W. Otherwise addresses wrap and rewrite or reread.

Test Plan:
- Fill write: cmd(addr=2,len=3,write=1,data=0xA5), seg_ready=1 -> tokens addr 2,3,4,5 with write_d=1, dataW_d=0xA5 on 4 consecutive cycles. burst_done pulses once. Outstanding stays 0.
- Wrap read: cmd(addr=14,len=3,write=0), segment model returns mem[a]=a+0x10 one cycle later -> addr_d 14,15,0,1. rd_data 0x1E,0x1F,0x10,0x11 in order.
- Credit stall: MAX_OUT=4, read len=7, segment withholds dataR_valid -> exactly 4 tokens issued, then seg_valid=0. Releasing one response issues the 5th token within 1 cycle.
- Backpressure: seg_ready toggles 1,0,0,1 and rd_ready=0 for 3 cycles during a read burst -> token fields stable while stalled, dataR_ready=0 while rd_valid=1, no data lost or duplicated.
- Unexpected data: dataR_valid=1 with dataR_d=0x3C while idle with 0 outstanding -> rd_data=0x3C forwarded, err_unexp=1 and held, outstanding=0.
- Reset mid-burst: assert reset during token 2 of a len=5 burst -> all outputs at reset values asynchronously. After release, cmd_ready=1 and a new len=0 write issues exactly one token.

Source files
------------

// File: rtl/segrw_initiator.sv
// segrw_initiator: initiator side of a segment read/write token stream.
// Expands burst commands (base, length, read/fill-write) into per-address
// segment tokens with address wrap-around. In-flight reads are limited by a
// credit counter, and returned read data goes out in order through a
// one-entry registered buffer.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   cmd_addr/data/write/len       burst command payload (len = words - 1)
//   cmd_valid / cmd_ready         command handshake
//   addr_d/dataW_d/write_d        registered segment token fields
//   seg_valid / seg_ready         segment token handshake
//   dataR_d, dataR_valid/ready    read data returned by the segment
//   rd_data, rd_valid/rd_ready    read result to downstream
//   burst_done                    one-cycle pulse after a burst's last token
//   err_unexp                     sticky: read data seen with nothing outstanding
module segrw_initiator #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_write,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [ADDR_W-1:0] addr_d,
    output logic [DATA_W-1:0] dataW_d,
    output logic              write_d,
    output logic              seg_valid,
    input  logic              seg_ready,
    input  logic [DATA_W-1:0] dataR_d,
    input  logic              dataR_valid,
    output logic              dataR_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              burst_done,
    output logic              err_unexp
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  remaining_nxt;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] dataw_nxt;
    logic              write_nxt;
    logic              cmd_ready_nxt;
    logic              seg_valid_nxt;
    logic              burst_done_nxt;
    logic              err_unexp_nxt;
    logic              rd_valid_nxt;
    logic [DATA_W-1:0] rd_data_nxt;

    logic cmd_fire;
    logic tok_fire;
    logic rd_tok_fire;
    logic rsp_fire;

    // Return buffer can take a word when empty or draining this cycle.
    assign dataR_ready = !rd_valid || rd_ready;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign tok_fire    = seg_valid && seg_ready;
    assign rd_tok_fire = tok_fire && !write_d;
    assign rsp_fire    = dataR_valid && dataR_ready;

    // Next-state, credit and output computation.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        addr_nxt       = addr_d;
        dataw_nxt      = dataW_d;
        write_nxt      = write_d;
        burst_done_nxt = 1'b0;
        outstanding_nxt = outstanding;
        rd_valid_nxt   = rd_valid;
        rd_data_nxt    = rd_data;

        // Simultaneous issue and return cancel; a return with nothing
        // outstanding is flagged and the counter is held at zero.
        if (rd_tok_fire && !rsp_fire) begin
            outstanding_nxt = outstanding + CNT_W'(1);
        end else if (!rd_tok_fire && rsp_fire && (outstanding != '0)) begin
            outstanding_nxt = outstanding - CNT_W'(1);
        end
        err_unexp_nxt = err_unexp || (rsp_fire && (outstanding == '0));

        if (rsp_fire) begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = dataR_d;
        end else if (rd_ready) begin
            rd_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nxt     = ISSUE;
                    addr_nxt      = cmd_addr;
                    dataw_nxt     = cmd_data;
                    write_nxt     = cmd_write;
                    remaining_nxt = cmd_len;
                end
            end
            ISSUE: begin
                if (tok_fire) begin
                    addr_nxt      = addr_d + ADDR_W'(1);
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining == '0) begin
                        state_nxt      = IDLE;
                        burst_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
        // Reads stall once the credit pool is exhausted; writes never stall.
        seg_valid_nxt = (state_nxt == ISSUE) && (write_nxt || (outstanding_nxt != MAX_CNT));
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            remaining   <= '0;
            outstanding <= '0;
            addr_d      <= '0;
            dataW_d     <= '0;
            write_d     <= 1'b0;
            cmd_ready   <= 1'b0;
            seg_valid   <= 1'b0;
            burst_done  <= 1'b0;
            err_unexp   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_nxt;
            remaining   <= remaining_nxt;
            outstanding <= outstanding_nxt;
            addr_d      <= addr_nxt;
            dataW_d     <= dataw_nxt;
            write_d     <= write_nxt;
            cmd_ready   <= cmd_ready_nxt;
            seg_valid   <= seg_valid_nxt;
            burst_done  <= burst_done_nxt;
            err_unexp   <= err_unexp_nxt;
            rd_valid    <= rd_valid_nxt;
            rd_data     <= rd_data_nxt;
        end
    end

    // Credit pool never overflows.
    a_credit_max: assert property (@(posedge clock) disable iff (!reset)
        outstanding <= MAX_CNT);

    // A presented token holds still until consumed.
    a_token_stable: assert property (@(posedge clock) disable iff (!reset)
        (seg_valid && !seg_ready) |=>
            (seg_valid && $stable(addr_d) && $stable(dataW_d) && $stable(write_d)));

endmodule

// File: tb/tb_segrw_initiator.sv
// Self-checking bench for segrw_initiator: a transaction-level model
// (expected token list per burst, credit count, ordered read results)
// is compared against the DUT every cycle, plus directed literal checks.
module tb_segrw_initiator;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned MAX_OUT = 4;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       write;
        logic       last;
    } tok_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              cmd_write = 1'b0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dataW_d;
    logic              write_d;
    logic              seg_valid;
    logic              seg_ready = 1'b1;
    logic [DATA_W-1:0] dataR_d = '0;
    logic              dataR_valid = 1'b0;
    logic              dataR_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic              burst_done;
    logic              err_unexp;

    segrw_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_write(cmd_write),
        .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .addr_d(addr_d), .dataW_d(dataW_d), .write_d(write_d),
        .seg_valid(seg_valid), .seg_ready(seg_ready),
        .dataR_d(dataR_d), .dataR_valid(dataR_valid), .dataR_ready(dataR_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .burst_done(burst_done), .err_unexp(err_unexp)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model state
    tok_t       exp_tok[$];
    logic [7:0] exp_rd[$];
    int         m_out = 0;
    bit         m_err = 1'b0;
    bit         m_buf_v = 1'b0;
    logic [7:0] m_buf_d = '0;
    bit         done_pend = 1'b0;
    bit         prev_stall = 1'b0;
    logic [3:0] p_addr;
    logic [7:0] p_data;
    logic       p_write;
    int         cyc = 0;
    int         done_cnt = 0;

    // Observation logs for literal checks
    logic [3:0] tok_log[$];
    int         tok_cyc[$];
    logic [7:0] rd_log[$];

    // Segment model: mem[a] = a + 0x10, answered one cycle after the token
    logic [7:0] seg_q[$];
    bit         seg_hold = 1'b0;
    bit         manual_rsp = 1'b0;
    bit         n_rtok = 1'b0;
    bit         n_rsp_acc = 1'b0;
    logic [3:0] n_rtok_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then model update for the coming edge.
    always @(negedge clock) begin
        bit   tok;
        bit   acc;
        bit   exp_sv;
        bit   done_nxt;
        tok_t t;
        if (!reset) begin
            exp_tok.delete();
            exp_rd.delete();
            m_out = 0;
            m_err = 1'b0;
            m_buf_v = 1'b0;
            m_buf_d = '0;
            done_pend = 1'b0;
            prev_stall = 1'b0;
            n_rtok = 1'b0;
            n_rsp_acc = 1'b0;
        end else begin
            cyc++;
            if (burst_done) done_cnt++;
            chk("burst_done", burst_done, done_pend);
            if (done_pend) chk("cmd_ready_after_burst", cmd_ready, 1);
            chk("dataR_ready", dataR_ready, (!m_buf_v || rd_ready));
            chk("rd_valid", rd_valid, m_buf_v);
            if (m_buf_v) chk("rd_data", rd_data, m_buf_d);
            chk("err_unexp", err_unexp, m_err);
            exp_sv = 1'b0;
            if (exp_tok.size() > 0) exp_sv = exp_tok[0].write || (m_out < MAX_OUT);
            chk("seg_valid", seg_valid, exp_sv);
            if (exp_tok.size() > 0) begin
                chk("cmd_ready_busy", cmd_ready, 0);
                if (seg_valid) begin
                    chk("addr_d", addr_d, exp_tok[0].addr);
                    chk("write_d", write_d, exp_tok[0].write);
                    chk("dataW_d", dataW_d, exp_tok[0].data);
                end
            end
            if (prev_stall)
                chk("stall_hold", {seg_valid, addr_d, dataW_d, write_d},
                    {1'b1, p_addr, p_data, p_write});

            tok = seg_valid && seg_ready;
            acc = dataR_valid && dataR_ready;
            done_nxt = 1'b0;
            n_rtok = 1'b0;

            // End-to-end: results leave in the order reads were issued.
            if (rd_valid && rd_ready) begin
                rd_log.push_back(rd_data);
                if (exp_rd.size() == 0) chk("rd_spurious", 1, 0);
                else chk("rd_order", rd_data, exp_rd.pop_front());
            end

            if (tok) begin
                tok_log.push_back(addr_d);
                tok_cyc.push_back(cyc);
                if (exp_tok.size() == 0) chk("token_spurious", 1, 0);
                else begin
                    t = exp_tok.pop_front();
                    done_nxt = t.last;
                    if (!t.write) begin
                        n_rtok = 1'b1;
                        n_rtok_addr = t.addr;
                        exp_rd.push_back(8'({4'h0, t.addr}) + 8'h10);
                    end
                end
            end

            if (acc && m_out == 0) begin
                m_err = 1'b1;
                if (!n_rtok) exp_rd.push_back(dataR_d);
            end
            if (n_rtok && !acc) m_out++;
            else if (!n_rtok && acc && m_out > 0) m_out--;
            n_rsp_acc = acc;

            if (acc) begin
                m_buf_v = 1'b1;
                m_buf_d = dataR_d;
            end else if (rd_ready) begin
                m_buf_v = 1'b0;
            end

            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    t.addr  = 4'(int'(cmd_addr) + i);
                    t.data  = cmd_data;
                    t.write = cmd_write;
                    t.last  = (i == int'(cmd_len));
                    exp_tok.push_back(t);
                end
            end

            prev_stall = seg_valid && !seg_ready;
            p_addr = addr_d;
            p_data = dataW_d;
            p_write = write_d;
            done_pend = done_nxt;
        end
    end

    // One clock: advance past the edge, then let the segment model respond.
    task automatic tick();
        @(posedge clock);
        #1;
        if (!reset) begin
            seg_q.delete();
        end else begin
            if (n_rsp_acc && seg_q.size() > 0) void'(seg_q.pop_front());
            if (n_rtok) seg_q.push_back(8'({4'h0, n_rtok_addr}) + 8'h10);
        end
        if (!manual_rsp) begin
            if (seg_hold || seg_q.size() == 0) begin
                dataR_valid = 1'b0;
                dataR_d = '0;
            end else begin
                dataR_valid = 1'b1;
                dataR_d = seg_q[0];
            end
        end
    endtask

    task automatic send_cmd(input logic [3:0] a, input logic [7:0] d, input logic w,
                            input logic [3:0] l);
        bit ok = 1'b0;
        cmd_addr = a;
        cmd_data = d;
        cmd_write = w;
        cmd_len = l;
        cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (exp_tok.size() == 0 && exp_rd.size() == 0 && !m_buf_v && cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ea[4];
        logic [7:0] ed[4];
        int d0;

        // Reset values
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_seg_valid", seg_valid, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_err_unexp", err_unexp, 0);
        chk("rst_token", {addr_d, dataW_d, write_d}, 0);
        chk("rst_dataR_ready", dataR_ready, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Fill write: 2,3,4,5 on consecutive cycles
        tok_log.delete(); tok_cyc.delete(); d0 = done_cnt;
        send_cmd(4'd2, 8'hA5, 1'b1, 4'd3);
        wait_idle();
        tick();
        ea = '{4'd2, 4'd3, 4'd4, 4'd5};
        chk("fill_count", tok_log.size(), 4);
        for (int i = 0; i < 4 && i < tok_log.size(); i++) chk("fill_addr", tok_log[i], ea[i]);
        if (tok_cyc.size() == 4) chk("fill_consecutive", tok_cyc[3] - tok_cyc[0], 3);
        chk("fill_done_once", done_cnt - d0, 1);
        chk("fill_no_responses", seg_q.size(), 0);

        // Wrap read: 14,15,0,1 -> 1E,1F,10,11
        tok_log.delete(); rd_log.delete();
        send_cmd(4'd14, 8'h00, 1'b0, 4'd3);
        wait_idle();
        ea = '{4'd14, 4'd15, 4'd0, 4'd1};
        ed = '{8'h1E, 8'h1F, 8'h10, 8'h11};
        chk("wrap_tok_count", tok_log.size(), 4);
        for (int i = 0; i < 4 && i < tok_log.size(); i++) chk("wrap_addr", tok_log[i], ea[i]);
        chk("wrap_rd_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("wrap_rd_data", rd_log[i], ed[i]);

        // Credit stall: 4 tokens then stall; one response frees the 5th
        tok_log.delete(); rd_log.delete();
        seg_hold = 1'b1;
        send_cmd(4'd0, 8'h00, 1'b0, 4'd7);
        repeat (10) tick();
        chk("credit_tokens", tok_log.size(), 4);
        chk("credit_stall", seg_valid, 0);
        seg_hold = 1'b0;
        tick();
        seg_hold = 1'b1;
        tick();
        chk("credit_release", seg_valid, 1);
        tick();
        chk("credit_fifth", tok_log.size(), 5);
        seg_hold = 1'b0;
        wait_idle();
        chk("credit_rd_count", rd_log.size(), 8);
        for (int i = 0; i < 8 && i < rd_log.size(); i++)
            chk("credit_rd_data", rd_log[i], 8'h10 + 8'(i));

        // Backpressure on both sides
        rd_log.delete();
        send_cmd(4'd5, 8'h00, 1'b0, 4'd3);
        for (int i = 0; i < 8; i++) begin
            seg_ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            rd_ready = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
            tick();
        end
        seg_ready = 1'b1;
        rd_ready = 1'b1;
        wait_idle();
        ed = '{8'h15, 8'h16, 8'h17, 8'h18};
        chk("bp_rd_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("bp_rd_data", rd_log[i], ed[i]);

        // Unexpected read data while idle
        manual_rsp = 1'b1;
        dataR_d = 8'h3C;
        dataR_valid = 1'b1;
        tick();
        dataR_valid = 1'b0;
        chk("unexp_rd_valid", rd_valid, 1);
        chk("unexp_rd_data", rd_data, 8'h3C);
        chk("unexp_err", err_unexp, 1);
        repeat (3) tick();
        chk("unexp_err_sticky", err_unexp, 1);
        chk("unexp_seg_idle", seg_valid, 0);
        manual_rsp = 1'b0;

        // Reset during token 2 of a 6-word write burst
        send_cmd(4'd3, 8'h5A, 1'b1, 4'd5);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_seg_valid", seg_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_token", {addr_d, dataW_d, write_d}, 0);
        chk("mid_rst_err", err_unexp, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_done", burst_done, 0);
        chk("mid_rst_dataR_ready", dataR_ready, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);
        tok_log.delete(); d0 = done_cnt;
        send_cmd(4'd9, 8'h77, 1'b1, 4'd0);
        wait_idle();
        repeat (3) tick();
        chk("single_tok_count", tok_log.size(), 1);
        if (tok_log.size() > 0) chk("single_tok_addr", tok_log[0], 4'd9);
        chk("single_tok_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
